// File: rtl/mcs8_pkg.sv
// Shared encodings for the MCS8 bus interface: core T-states, bus cycle
// types and the bus-interface FSM states.
package mcs8_pkg;

    typedef enum logic [2:0] {
        WAIT = 3'b000,
        T3   = 3'b001,
        T1   = 3'b010,
        STOP = 3'b011,
        T2   = 3'b100,
        T5   = 3'b101,
        T1I  = 3'b110,
        T4   = 3'b111
    } CpuState;

    typedef enum logic [1:0] {
        CYCLE_PCI = 2'b00,
        CYCLE_PCC = 2'b01,
        CYCLE_PCR = 2'b10,
        CYCLE_PCW = 2'b11
    } CycleType;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_L = 3'd1,
        DECODE = 3'd2,
        ACCESS = 3'd3,
        WDATA  = 3'd4,
        DONE   = 3'd5
    } FsmState;

    // A cycle returns data to the core for fetches, reads and I/O input
    // (I/O input is the PCC group whose high address bits [5:4] are zero).
    function automatic logic isReadCycle(input CycleType cyc, input logic [5:0] hi);
        return (cyc == CYCLE_PCI) || (cyc == CYCLE_PCR) ||
               ((cyc == CYCLE_PCC) && (hi[5:4] == 2'b00));
    endfunction

endpackage

// File: rtl/mcs8_busif_if.sv
// Core-side, memory-side and I/O-side signals of the MCS8 bus interface.
// The slave modport is the bus interface unit; master is its environment.
interface mcs8_busif_if;

    logic       sync;
    logic [2:0] cpuState;
    logic [7:0] cpuDat;
    logic [7:0] coreDat;
    logic       coreDatOe;
    logic       ready;
    logic       intReq;
    logic       coreInt;
    logic [13:0] memAddr;
    logic       memRd;
    logic       memWr;
    logic [7:0] memWdat;
    logic [7:0] memRdat;
    logic       memAck;
    logic [4:0] ioPort;
    logic       ioRd;
    logic       ioWr;
    logic [7:0] ioWdat;
    logic [7:0] ioRdat;
    logic       ioAck;
    logic       err;

    modport slave (
        input  sync, cpuState, cpuDat, intReq, memRdat, memAck, ioRdat, ioAck,
        output coreDat, coreDatOe, ready, coreInt, memAddr, memRd, memWr, memWdat,
               ioPort, ioRd, ioWr, ioWdat, err
    );

    modport master (
        output sync, cpuState, cpuDat, intReq, memRdat, memAck, ioRdat, ioAck,
        input  coreDat, coreDatOe, ready, coreInt, memAddr, memRd, memWr, memWdat,
               ioPort, ioRd, ioWr, ioWdat, err
    );

endinterface

// File: rtl/mcs8_busif_timer.sv
// Access timeout counter: counts clocks while enabled, flags expiry on the
// TIMEOUT-th enabled clock so the owner can force completion on that edge.
module mcs8_busif_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [3:0] count;

    // Count clocks spent waiting; restart from zero whenever cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign expire = enable && (count == 4'(TIMEOUT - 1));

endmodule

// File: rtl/mcs8_busif.sv
// MCS8 bus interface unit: demultiplexes the core's T1/T2/T3 bus into a
// memory port and an I/O port, stalls the core via READY, and supplies the
// restart opcode during interrupt acknowledge.
module mcs8_busif
    import mcs8_pkg::*;
#(
    parameter logic [7:0] INT_OPCODE = 8'h05,
    parameter int         TIMEOUT    = 15,
    parameter logic [7:0] ERR_DATA   = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    mcs8_busif_if.slave bus
);

    FsmState    fsm;
    CycleType   cycType;
    CpuState    coreSt;
    logic [7:0] addrLo;
    logic [5:0] addrHi;
    logic [7:0] dataReg;
    logic       intAck;
    logic       intBlock;
    logic       memRd, memWr, ioRd, ioWr;
    logic [7:0] memWdat, ioWdat;
    logic [4:0] ioPort;
    logic       ready, err, coreInt;
    logic       newCycle, strobeT1I, strobeT2, strobeT3;
    logic       ackIn, expire, isRead;

    assign coreSt    = CpuState'(bus.cpuState);
    assign strobeT1I = bus.sync && (coreSt == T1I);
    assign newCycle  = bus.sync && ((coreSt == T1) || (coreSt == T1I));
    assign strobeT2  = bus.sync && (coreSt == T2);
    assign strobeT3  = bus.sync && (coreSt == T3);
    assign ackIn     = ((memRd | memWr) & bus.memAck) | ((ioRd | ioWr) & bus.ioAck);
    assign isRead    = isReadCycle(cycType, addrHi);

    mcs8_busif_timer #(.TIMEOUT(TIMEOUT)) timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (fsm != ACCESS),
        .enable (fsm == ACCESS),
        .expire (expire)
    );

    // Bus cycle sequencer: latches address bytes, issues requests, waits for
    // ack or timeout, and aborts on an unexpected new T1/T1I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            cycType <= CYCLE_PCI;
            addrLo  <= 8'h00;
            addrHi  <= 6'h00;
            dataReg <= 8'h00;
            intAck  <= 1'b0;
            memRd   <= 1'b0;
            memWr   <= 1'b0;
            ioRd    <= 1'b0;
            ioWr    <= 1'b0;
            memWdat <= 8'h00;
            ioWdat  <= 8'h00;
            ioPort  <= 5'h00;
            ready   <= 1'b1;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            if ((fsm == DECODE || fsm == WDATA || fsm == ACCESS) && newCycle) begin
                err    <= 1'b1;
                memRd  <= 1'b0;
                memWr  <= 1'b0;
                ioRd   <= 1'b0;
                ioWr   <= 1'b0;
                ready  <= 1'b1;
                addrLo <= bus.cpuDat;
                intAck <= strobeT1I;
                fsm    <= ADDR_L;
            end else begin
                case (fsm)
                    IDLE, DONE: begin
                        intAck <= 1'b0;
                        if (newCycle) begin
                            addrLo <= bus.cpuDat;
                            intAck <= strobeT1I;
                            fsm    <= ADDR_L;
                        end
                    end
                    ADDR_L: begin
                        if (strobeT2) begin
                            addrHi  <= bus.cpuDat[5:0];
                            cycType <= CycleType'(bus.cpuDat[7:6]);
                            ready   <= intAck;
                            fsm     <= DECODE;
                        end else if (newCycle) begin
                            addrLo <= bus.cpuDat;
                            intAck <= strobeT1I;
                        end
                    end
                    DECODE: begin
                        case (cycType)
                            CYCLE_PCI, CYCLE_PCR: begin
                                if (cycType == CYCLE_PCI && intAck) begin
                                    dataReg <= INT_OPCODE;
                                    fsm     <= DONE;
                                end else begin
                                    memRd <= 1'b1;
                                    fsm   <= ACCESS;
                                end
                            end
                            CYCLE_PCW: begin
                                ready <= 1'b1;
                                fsm   <= WDATA;
                            end
                            CYCLE_PCC: begin
                                ioPort <= addrHi[5:1];
                                if (addrHi[5:4] == 2'b00) begin
                                    ioRd <= 1'b1;
                                end else begin
                                    ioWdat <= addrLo;
                                    ioWr   <= 1'b1;
                                end
                                fsm <= ACCESS;
                            end
                            default: fsm <= IDLE;
                        endcase
                    end
                    WDATA: begin
                        if (strobeT3) begin
                            memWdat <= bus.cpuDat;
                            ready   <= 1'b0;
                            memWr   <= 1'b1;
                            fsm     <= ACCESS;
                        end
                    end
                    ACCESS: begin
                        if (ackIn || expire) begin
                            if (isRead) begin
                                dataReg <= !ackIn ? ERR_DATA : (memRd ? bus.memRdat : bus.ioRdat);
                            end
                            err   <= !ackIn;
                            memRd <= 1'b0;
                            memWr <= 1'b0;
                            ioRd  <= 1'b0;
                            ioWr  <= 1'b0;
                            ready <= 1'b1;
                            fsm   <= DONE;
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

    // Interrupt forwarding: registered request, masked from the clock after
    // an acknowledge until the source has been seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intBlock <= 1'b0;
            coreInt  <= 1'b0;
        end else begin
            coreInt <= bus.intReq && !intBlock;
            if (strobeT1I) begin
                intBlock <= 1'b1;
            end else if (!bus.intReq) begin
                intBlock <= 1'b0;
            end
        end
    end

    assign bus.coreDatOe = (fsm == DONE) && isRead && (coreSt == T3);
    assign bus.coreDat   = bus.coreDatOe ? dataReg : 8'h00;
    assign bus.memAddr   = {addrHi, addrLo};
    assign bus.memRd     = memRd;
    assign bus.memWr     = memWr;
    assign bus.memWdat   = memWdat;
    assign bus.ioPort    = ioPort;
    assign bus.ioRd      = ioRd;
    assign bus.ioWr      = ioWr;
    assign bus.ioWdat    = ioWdat;
    assign bus.ready     = ready;
    assign bus.err       = err;
    assign bus.coreInt   = coreInt;

endmodule

// File: tb/tb_mcs8_busif.sv
// Testbench for mcs8_busif: emulates the core's strobed bus and the memory /
// I/O responders, predicting results from a transaction-level model.
module tb_mcs8_busif;

    localparam logic [2:0] S_T1  = 3'b010;
    localparam logic [2:0] S_T2  = 3'b100;
    localparam logic [2:0] S_T3  = 3'b001;
    localparam logic [2:0] S_T1I = 3'b110;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mcs8_busif_if bus();

    mcs8_busif dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] st, input logic [7:0] d);
        bus.sync     = 1'b1;
        bus.cpuState = st;
        bus.cpuDat   = d;
        tick();
        bus.sync = 1'b0;
    endtask

    // One complete core bus cycle; kind is the cycle type (0 PCI, 1 PCC,
    // 2 PCR, 3 PCW). ackDelay is the request clock in which the responder
    // acks; values above 15 model a responder that never answers.
    task automatic runCycle(input int kind, input logic [7:0] lo, input logic [5:0] hi,
                            input logic [7:0] wdata, input logic [7:0] rdata, input int ackDelay);
        logic [1:0] cyc;
        bit   isIo, isOut, isWrite, isRd, expErr, req;
        int   expReq, reqCycles, errPulses, nReq;
        logic [7:0] expData;
        cyc     = 2'(kind);
        isIo    = (cyc == 2'b01);
        isOut   = isIo && (hi[5:4] != 2'b00);
        isWrite = (cyc == 2'b11);
        isRd    = !isWrite && !isOut;
        expErr  = (ackDelay > 15);
        expReq  = expErr ? 15 : ackDelay;
        expData = expErr ? 8'hFF : rdata;

        strobe(S_T1, lo);
        strobe(S_T2, {cyc, hi});
        vectors++;
        if (bus.ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL decode_ready: got %b expected 0", bus.ready);
        end
        if (isWrite) begin
            tick();
            vectors++;
            if ({bus.ready, bus.memWr} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL wdata_wait: got ready/memWr %b expected 10", {bus.ready, bus.memWr});
            end
            strobe(S_T3, wdata);
        end else begin
            tick();
        end

        reqCycles = 0;
        errPulses = 0;
        for (int guard = 0; guard < 40; guard++) begin
            req = isIo ? (isOut ? bus.ioWr : bus.ioRd) : (isWrite ? bus.memWr : bus.memRd);
            if (!req) break;
            reqCycles++;
            if (reqCycles == 1) begin
                nReq = int'(bus.memRd) + int'(bus.memWr) + int'(bus.ioRd) + int'(bus.ioWr);
                vectors++;
                if (nReq != 1 || bus.ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL request_shape: got %0d requests ready %b expected 1 and 0", nReq, bus.ready);
                end
                vectors++;
                if (isIo) begin
                    if (bus.ioPort !== hi[5:1] || (isOut && bus.ioWdat !== lo)) begin
                        miscompares++;
                        $display("[TB] FAIL io_port_data: got port %h data %h expected port %h data %h",
                                 bus.ioPort, bus.ioWdat, hi[5:1], lo);
                    end
                end else begin
                    if (bus.memAddr !== {hi, lo} || (isWrite && bus.memWdat !== wdata)) begin
                        miscompares++;
                        $display("[TB] FAIL mem_addr_data: got addr %h wdat %h expected addr %h wdat %h",
                                 bus.memAddr, bus.memWdat, {hi, lo}, wdata);
                    end
                end
            end
            if (reqCycles == ackDelay) begin
                if (isIo) begin
                    bus.ioAck  = 1'b1;
                    bus.ioRdat = rdata;
                end else begin
                    bus.memAck  = 1'b1;
                    bus.memRdat = rdata;
                end
            end
            tick();
            bus.memAck  = 1'b0;
            bus.ioAck   = 1'b0;
            bus.memRdat = 8'($urandom);
            bus.ioRdat  = 8'($urandom);
            if (bus.err) errPulses++;
        end

        vectors++;
        if (reqCycles != expReq) begin
            miscompares++;
            $display("[TB] FAIL request_length: got %0d clocks expected %0d", reqCycles, expReq);
        end
        vectors++;
        if (errPulses != int'(expErr) || bus.ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL completion: got err %0d ready %b expected err %0d ready 1",
                     errPulses, bus.ready, int'(expErr));
        end
        tick();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_single_pulse: got %b expected 0", bus.err);
        end

        bus.cpuState = S_T3;
        bus.sync     = 1'b1;
        #1;
        vectors++;
        if (isRd) begin
            if (bus.coreDatOe !== 1'b1 || bus.coreDat !== expData) begin
                miscompares++;
                $display("[TB] FAIL t3_read_data: got oe %b data %h expected oe 1 data %h",
                         bus.coreDatOe, bus.coreDat, expData);
            end
        end else if (bus.coreDatOe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL t3_no_drive: got oe %b expected 0", bus.coreDatOe);
        end
        tick();
        bus.sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sync = 1'b0; bus.cpuState = 3'b000; bus.cpuDat = 8'h00; bus.intReq = 1'b0;
        bus.memRdat = 8'h00; bus.memAck = 1'b0; bus.ioRdat = 8'h00; bus.ioAck = 1'b0;
        #3;
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready);
        end
        vectors++;
        if ({bus.coreDat, bus.coreDatOe, bus.coreInt, bus.memAddr, bus.memRd, bus.memWr, bus.memWdat,
             bus.ioPort, bus.ioRd, bus.ioWr, bus.ioWdat, bus.err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got addr %h rd %b wr %b port %h err %b expected all zero",
                     bus.memAddr, bus.memRd, bus.memWr, bus.ioPort, bus.err);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        runCycle(0, 8'h34, 6'h12, 8'h00, 8'hC0, 3);
    endtask

    task automatic test_write();
        runCycle(3, 8'h80, 6'h01, 8'h5A, 8'h00, 4);
    endtask

    task automatic test_io();
        runCycle(1, 8'h77, 6'h12, 8'h00, 8'h00, 2);
        runCycle(1, 8'h10, 6'h0E, 8'h00, 8'hA5, 1);
    endtask

    task automatic test_interrupt();
        bit sawReq;
        bus.intReq = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.coreInt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL int_forward: got %b expected 1", bus.coreInt);
        end
        strobe(S_T1I, 8'h00);
        strobe(S_T2, 8'h00);
        vectors++;
        if ({bus.coreInt, bus.ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL int_ack_t2: got int/ready %b expected 01", {bus.coreInt, bus.ready});
        end
        sawReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.memRd || bus.memWr || bus.ioRd || bus.ioWr || !bus.ready) sawReq = 1'b1;
        end
        vectors++;
        if (sawReq) begin
            miscompares++;
            $display("[TB] FAIL int_ack_no_access: got request or stall expected none");
        end
        bus.cpuState = S_T3;
        bus.sync     = 1'b1;
        #1;
        vectors++;
        if (bus.coreDatOe !== 1'b1 || bus.coreDat !== 8'h05) begin
            miscompares++;
            $display("[TB] FAIL int_opcode: got oe %b data %h expected oe 1 data 05",
                     bus.coreDatOe, bus.coreDat);
        end
        tick();
        bus.sync = 1'b0;
        vectors++;
        if (bus.coreInt !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL int_held_clear: got %b expected 0", bus.coreInt);
        end
        bus.intReq = 1'b0;
        tick();
        tick();
        bus.intReq = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.coreInt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL int_rearm: got %b expected 1", bus.coreInt);
        end
        bus.intReq = 1'b0;
        tick();
        tick();
        runCycle(0, 8'h42, 6'h3F, 8'h00, 8'h9C, 2);
    endtask

    task automatic test_timeout();
        runCycle(2, 8'($urandom), 6'($urandom), 8'h00, 8'h00, 99);
    endtask

    task automatic test_protocol_error();
        strobe(S_T1, 8'h11);
        strobe(S_T2, {2'b10, 6'h05});
        tick();
        vectors++;
        if (bus.memRd !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL proto_pre_request: got %b expected 1", bus.memRd);
        end
        strobe(S_T1, 8'hE7);
        vectors++;
        if ({bus.err, bus.memRd, bus.ready} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL proto_abort: got err/rd/ready %b expected 101",
                     {bus.err, bus.memRd, bus.ready});
        end
        tick();
        strobe(S_T2, {2'b10, 6'h2A});
        tick();
        vectors++;
        if (bus.memRd !== 1'b1 || bus.memAddr !== 14'h2AE7) begin
            miscompares++;
            $display("[TB] FAIL proto_restart: got rd %b addr %h expected rd 1 addr 2ae7",
                     bus.memRd, bus.memAddr);
        end
        bus.memAck  = 1'b1;
        bus.memRdat = 8'h3C;
        tick();
        bus.memAck = 1'b0;
        bus.cpuState = S_T3;
        bus.sync     = 1'b1;
        #1;
        vectors++;
        if (bus.ready !== 1'b1 || bus.coreDat !== 8'h3C) begin
            miscompares++;
            $display("[TB] FAIL proto_restart_data: got ready %b data %h expected ready 1 data 3c",
                     bus.ready, bus.coreDat);
        end
        tick();
        bus.sync = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        strobe(S_T1, 8'h55);
        strobe(S_T2, {2'b10, 6'h21});
        tick();
        tick();
        vectors++;
        if (bus.memRd !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_pre: got %b expected 1", bus.memRd);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.memRd, bus.ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL midreset_async: got rd/ready %b expected 01", {bus.memRd, bus.ready});
        end
        tick();
        rst = 1'b0;
        bus.memAck  = 1'b1;
        bus.memRdat = 8'hEE;
        tick();
        bus.memAck = 1'b0;
        vectors++;
        if ({bus.memRd, bus.ready, bus.err} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL midreset_late_ack: got rd/ready/err %b expected 010",
                     {bus.memRd, bus.ready, bus.err});
        end
        runCycle(2, 8'h01, 6'h02, 8'h00, 8'h77, 2);
    endtask

    task automatic test_random();
        int kind, delay;
        for (int n = 0; n < 25; n++) begin
            kind  = int'($urandom_range(0, 3));
            delay = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6));
            runCycle(kind, 8'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), delay);
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fetch();
        test_write();
        test_io();
        test_interrupt();
        test_timeout();
        test_protocol_error();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcs8_busif.md
Name: mcs8_busif

Overview:
- Bus interface unit that sits directly downstream of the MCS8 CPU core.
- Consumes the core's multiplexed 8-bit bus: address low at T1, cycle type plus address high at T2, data at T3.
- Drives a demultiplexed 14-bit memory port and a 5-bit I/O port, throttles the core through READY, and jams a restart opcode during interrupt acknowledge (T1I).

Parameters:
INT_OPCODE, 8'h05, opcode returned on interrupt-acknowledge fetch (RST 0)
TIMEOUT, 15, max clocks waiting for MEM_ACK_I/IO_ACK_I before forced completion (4-bit counter, 1..15)
ERR_DATA, 8'hFF, data returned to the core on timeout

Ports:
CLK_I  in  1  system clock
RST_I  in  1  reset
SYNC_I  in  1  core SYNC; STATE_I/CPU_DAT_I sampled only on rising CLK_I while SYNC_I=1 ("strobe")
STATE_I  in  3  core state: T1=010 T2=100 T3=001 T4=111 T5=101 T1I=110 STOP=011 WAIT=000
CPU_DAT_I  in  8  core bus output
CPU_DAT_O  out  8  data to core
CPU_DAT_OE_O  out  1  CPU_DAT_O valid (core samples during T3)
READY_O  out  1  to core READY; 0 holds core in WAIT
INT_I  in  1  external interrupt request, level
INT_O  out  1  to core INT
MEM_ADDR_O  out  14  memory address
MEM_RD_O  out  1  read request, level until ack
MEM_WR_O  out  1  write request, level until ack
MEM_WDAT_O  out  8  write data
MEM_RDAT_I  in  8  read data, valid with MEM_ACK_I
MEM_ACK_I  in  1  memory completion
IO_PORT_O  out  5  I/O port number
IO_RD_O  out  1  input request
IO_WR_O  out  1  output request
IO_WDAT_O  out  8  output data
IO_RDAT_I  in  8  input data
IO_ACK_I  in  1  I/O completion
ERR_O  out  1  one-clock pulse on timeout or protocol error

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs 0 except READY_O=1.
  - FSM returns to IDLE; latches cleared; any pending request is dropped without ack.
- Cycle type = T2 byte [7:6]: 00 PCI (fetch), 01 PCC (I/O), 10 PCR (read), 11 PCW (write). Address high = T2 byte [5:0].
- FSM states: IDLE, ADDR_L, DECODE, ACCESS, WDATA, DONE.
  - IDLE: T1 strobe latches ADDR_LO; T1I strobe latches ADDR_LO and sets int_ack. Both go to ADDR_L.
  - ADDR_L: T2 strobe latches ADDR_HI and type, goes to DECODE; READY_O falls on the same edge unless the cycle is int_ack.
  - DECODE, one clock:
    - PCI/PCR: assert MEM_RD_O, go to ACCESS.
    - PCI with int_ack: load INT_OPCODE into the data register, go to DONE; no memory access.
    - PCW: go to WDATA.
    - PCC: IO_PORT_O = ADDR_HI[5:1].
      - ADDR_HI[5:4]==00: assert IO_RD_O, go to ACCESS.
      - Otherwise (OUT): IO_WDAT_O = ADDR_LO (accumulator); assert IO_WR_O, go to ACCESS.
  - WDATA: raise READY_O so the core reaches T3. T3 strobe latches CPU_DAT_I into MEM_WDAT_O, drops READY_O, asserts MEM_WR_O, goes to ACCESS.
  - ACCESS: hold the request until ack, then deassert the request and go to DONE.
    - A read captures RDAT into the data register.
    - Ack in the same clock the request first rises is legal and completes.
  - DONE: READY_O=1.
    - For reads, CPU_DAT_OE_O=1 with CPU_DAT_O = data register while STATE_I=T3.
    - Next T1/T1I strobe re-enters the ADDR_L path.
    - Writes and OUT require no T3 drive.
- Memory address: MEM_ADDR_O = {ADDR_HI[5:0], ADDR_LO}, stable from DECODE until ack.
- Timeout: 4-bit counter counts clocks in ACCESS.
  - At count==TIMEOUT: drop the request, load ERR_DATA for reads, pulse ERR_O, go to DONE.
  - Counter clears on entry to ACCESS.
- Protocol error: a T1 or T1I strobe while in DECODE/WDATA/ACCESS pulses ERR_O, aborts the request, and restarts at ADDR_L with the new low byte.
- Interrupts:
  - INT_O = INT_I registered.
  - INT_O clears on the clock after a T1I strobe and stays clear until INT_I is seen low.
  - int_ack clears in DONE.
- STOP/WAIT/T4/T5 strobes in IDLE/DONE: ignored.

Decomposition:
- Shared package mcs8_pkg:
  - state encodings: T1, T2, T3, T4, T5, T1I, STOP, WAIT
  - cycle encodings: CYCLE_PCI, CYCLE_PCC, CYCLE_PCR, CYCLE_PCW
  - FSM state encoding
- Sub-module mcs8_busif_timer: timeout counter with clear/enable/expire.

Test Plan:
- Fetch: T1 byte 34, T2 byte 0x12 (PCI, hi 0x12), MEM_ACK_I after 3 clocks with 8'hC0 -> MEM_ADDR_O=14'h1234, READY_O low 3 clocks, CPU_DAT_O=8'hC0 with OE during T3.
- Write: T2 byte 0xC1, T1 0x80, T3 data 0x5A -> MEM_WR_O with MEM_ADDR_O=14'h0180, MEM_WDAT_O=8'h5A, held until ack.
- I/O: OUT with T1=0x77, T2=0x52 -> IO_PORT_O=5'h09, IO_WDAT_O=8'h77, IO_WR_O. INP with T2=0x4E -> IO_RD_O, port 7, IO_RDAT_I returned at T3.
- Interrupt: INT_I=1, then T1I + T2 PCI -> INT_O cleared, no MEM_RD_O, CPU_DAT_O=8'h05 at T3.
- Timeout: PCR with no ack -> MEM_RD_O drops after 15 clocks, ERR_O one pulse, CPU_DAT_O=8'hFF.
- RST_I asserted mid-ACCESS -> MEM_RD_O=0 and READY_O=1 immediately; late ack ignored; next T1 starts cleanly.
